// File: rtl/cnn_pkg.sv
// Shared defaults, counter-width helpers and read-port naming for the CNN
// local weight memory.
package cnn_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int LANES_DEF      = 8;
    localparam int DEPTH_DEF      = 64;
    localparam int WORDS_USED_DEF = 50;

    // Width needed to count 0..n-1; a single-entry range still needs one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LANE_CNT_W = cntWidth(LANES_DEF);
    localparam int WORD_CNT_W = cntWidth(DEPTH_DEF);

    typedef enum logic {
        RD_PORT1 = 1'b0,
        RD_PORT2 = 1'b1
    } rdPortE;

endpackage

// File: rtl/cnn_weight_sram.sv
// Two-port weight SRAM: port A read/write with per-lane active-low write
// enables, port B read-only; both ports have a one-cycle registered read.
module cnn_weight_sram
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = cntWidth(DEPTH)
) (
    input  logic                    clk,
    input  logic                    i_aEn,
    input  logic [LANES-1:0]        i_aWenN,
    input  logic [ADDR_W-1:0]       i_aAddr,
    input  logic [LANES*DATA_W-1:0] i_aWdata,
    output logic [LANES*DATA_W-1:0] o_aRdata,
    input  logic                    i_bEn,
    input  logic [ADDR_W-1:0]       i_bAddr,
    output logic [LANES*DATA_W-1:0] o_bRdata
);

    logic [LANES*DATA_W-1:0] r_mem [DEPTH];
    logic [LANES*DATA_W-1:0] r_aRdata;
    logic [LANES*DATA_W-1:0] r_bRdata;

    // A port-A access with any lane enabled is a write; otherwise it is a read.
    always_ff @(posedge clk) begin
        if (i_aEn) begin
            for (int l = 0; l < LANES; l++) begin
                if (!i_aWenN[l]) begin
                    r_mem[i_aAddr][l*DATA_W +: DATA_W] <= i_aWdata[l*DATA_W +: DATA_W];
                end
            end
            if (&i_aWenN) begin
                r_aRdata <= r_mem[i_aAddr];
            end
        end
        if (i_bEn) begin
            r_bRdata <= r_mem[i_bAddr];
        end
    end

    assign o_aRdata = r_aRdata;
    assign o_bRdata = r_bRdata;

endmodule

// File: rtl/cnn_local_mem_weight_param.sv
// Packs a stream of weights LANES-per-word into a local SRAM and serves two
// one-cycle read ports, port 2 reading at a fixed word offset.
module cnn_local_mem_weight_param
    import cnn_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int WORDS_USED = WORDS_USED_DEF,
    parameter int RD2_OFFSET = 25
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    write_weight_signal,
    input  logic [DATA_W-1:0]       write_weight_data,
    input  logic                    read_weight_signal,
    input  logic [15:0]             read_weight_addr1,
    input  logic [15:0]             read_weight_addr2,
    output logic [LANES*DATA_W-1:0] read_weight_data1,
    output logic [LANES*DATA_W-1:0] read_weight_data2,
    output logic                    read_valid1,
    output logic                    read_valid2,
    output logic                    store_done
);

    localparam int LANE_W = cntWidth(LANES);
    localparam int ADDR_W = cntWidth(DEPTH);

    logic [LANE_W-1:0]       r_laneCnt;
    logic [ADDR_W-1:0]       r_wordCnt;
    logic                    r_storeDone;
    logic [1:0]              r_readValid;

    logic                    w_wrAccept;
    logic                    w_lastLane;
    logic                    w_lastWord;
    logic [ADDR_W-1:0]       w_rd1Addr;
    logic [ADDR_W-1:0]       w_rd2Addr;
    logic                    w_aEn;
    logic [LANES-1:0]        w_aWenN;
    logic [ADDR_W-1:0]       w_aAddr;
    logic [LANES*DATA_W-1:0] w_aWdata;
    logic [LANES*DATA_W-1:0] w_aRdata;
    logic [LANES*DATA_W-1:0] w_bRdata;

    assign w_wrAccept = write_weight_signal & ~load_start;
    assign w_lastLane = (r_laneCnt == LANE_W'(LANES - 1));
    assign w_lastWord = (r_wordCnt == ADDR_W'(WORDS_USED - 1));

    assign w_rd1Addr = ADDR_W'(32'(read_weight_addr1) % DEPTH);
    assign w_rd2Addr = ADDR_W'((32'(read_weight_addr2) + 32'(RD2_OFFSET)) % DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_laneCnt <= '0;
            r_wordCnt <= '0;
        end else if (load_start) begin
            r_laneCnt <= '0;
            r_wordCnt <= '0;
        end else if (w_wrAccept) begin
            if (w_lastLane) begin
                r_laneCnt <= '0;
                r_wordCnt <= w_lastWord ? '0 : r_wordCnt + 1'b1;
            end else begin
                r_laneCnt <= r_laneCnt + 1'b1;
            end
        end
    end

    // Sticky until the next load restart: later wrap-arounds keep it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_storeDone <= 1'b0;
        end else if (load_start) begin
            r_storeDone <= 1'b0;
        end else if (w_wrAccept && w_lastLane && w_lastWord) begin
            r_storeDone <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_readValid <= '0;
        end else begin
            r_readValid[RD_PORT1] <= read_weight_signal;
            r_readValid[RD_PORT2] <= read_weight_signal & ~w_wrAccept;
        end
    end

    // A write takes port A, so a simultaneous port-2 read is dropped.
    always_comb begin
        w_aEn   = 1'b0;
        w_aWenN = '1;
        w_aAddr = w_rd2Addr;
        if (w_wrAccept) begin
            w_aEn              = 1'b1;
            w_aWenN[r_laneCnt] = 1'b0;
            w_aAddr            = r_wordCnt;
        end else if (read_weight_signal) begin
            w_aEn = 1'b1;
        end
    end

    assign w_aWdata = {LANES{write_weight_data}};

    cnn_weight_sram #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk      (clk),
        .i_aEn    (w_aEn),
        .i_aWenN  (w_aWenN),
        .i_aAddr  (w_aAddr),
        .i_aWdata (w_aWdata),
        .o_aRdata (w_aRdata),
        .i_bEn    (read_weight_signal),
        .i_bAddr  (w_rd1Addr),
        .o_bRdata (w_bRdata)
    );

    assign read_valid1       = r_readValid[RD_PORT1];
    assign read_valid2       = r_readValid[RD_PORT2];
    assign read_weight_data1 = r_readValid[RD_PORT1] ? w_bRdata : '0;
    assign read_weight_data2 = r_readValid[RD_PORT2] ? w_aRdata : '0;
    assign store_done        = r_storeDone;

endmodule

// File: tb/tb_cnn_local_mem_weight_param.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against an array-based model of the packed weight store.
module tb_cnn_local_mem_weight_param;

    localparam int DW  = 16;
    localparam int L   = 8;
    localparam int D   = 64;
    localparam int WU  = 50;
    localparam int OFF = 25;
    localparam int SL  = 4;
    localparam int SD  = 32;
    localparam int SWU = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          loadStart = 1'b0;
    logic          wrSig = 1'b0;
    logic [DW-1:0] wrData = '0;
    logic          rdSig = 1'b0;
    logic [15:0]   rdAddr1 = '0;
    logic [15:0]   rdAddr2 = '0;
    logic [L*DW-1:0] rdData1;
    logic [L*DW-1:0] rdData2;
    logic          rdValid1;
    logic          rdValid2;
    logic          storeDone;

    logic          sLoadStart = 1'b0;
    logic          sWrSig = 1'b0;
    logic [DW-1:0] sWrData = '0;
    logic          sRdSig = 1'b0;
    logic [15:0]   sRdAddr1 = '0;
    logic [15:0]   sRdAddr2 = '0;
    logic [SL*DW-1:0] sRdData1;
    logic [SL*DW-1:0] sRdData2;
    logic          sRdValid1;
    logic          sRdValid2;
    logic          sStoreDone;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [DW-1:0] mMem   [D][L];
    bit            mKnown [D][L];
    int            mIdx  = 0;

    always #5 clk = ~clk;

    cnn_local_mem_weight_param #(
        .DATA_W(DW), .LANES(L), .DEPTH(D), .WORDS_USED(WU), .RD2_OFFSET(OFF)
    ) dut (
        .clk(clk), .rst(rst), .load_start(loadStart),
        .write_weight_signal(wrSig), .write_weight_data(wrData),
        .read_weight_signal(rdSig), .read_weight_addr1(rdAddr1), .read_weight_addr2(rdAddr2),
        .read_weight_data1(rdData1), .read_weight_data2(rdData2),
        .read_valid1(rdValid1), .read_valid2(rdValid2), .store_done(storeDone)
    );

    cnn_local_mem_weight_param #(
        .DATA_W(DW), .LANES(SL), .DEPTH(SD), .WORDS_USED(SWU), .RD2_OFFSET(OFF)
    ) dutSweep (
        .clk(clk), .rst(rst), .load_start(sLoadStart),
        .write_weight_signal(sWrSig), .write_weight_data(sWrData),
        .read_weight_signal(sRdSig), .read_weight_addr1(sRdAddr1), .read_weight_addr2(sRdAddr2),
        .read_weight_data1(sRdData1), .read_weight_data2(sRdData2),
        .read_valid1(sRdValid1), .read_valid2(sRdValid2), .store_done(sStoreDone)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        totalChecks++;
        if (obs !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [L*DW-1:0] modelWord(input int a);
        logic [L*DW-1:0] w;
        for (int l = 0; l < L; l++) w[l*DW +: DW] = mMem[a][l];
        return w;
    endfunction

    function automatic logic [L*DW-1:0] modelMask(input int a);
        logic [L*DW-1:0] m;
        for (int l = 0; l < L; l++) m[l*DW +: DW] = mKnown[a][l] ? '1 : '0;
        return m;
    endfunction

    // One clock of traffic on the main instance, checked against the model.
    task automatic applyStimulus(input bit ls, input bit wr, input logic [DW-1:0] wd,
                                 input bit rd, input logic [15:0] a1, input logic [15:0] a2);
        logic [L*DW-1:0] expD1, expD2, mask1, mask2;
        bit expV1, expV2;
        int w1, w2;
        loadStart = ls; wrSig = wr; wrData = wd;
        rdSig = rd; rdAddr1 = a1; rdAddr2 = a2;
        w1 = int'(a1) % D;
        w2 = (int'(a2) + OFF) % D;
        expV1 = rd;
        expV2 = rd && !(wr && !ls);
        expD1 = expV1 ? modelWord(w1) : '0;
        mask1 = expV1 ? modelMask(w1) : '1;
        expD2 = expV2 ? modelWord(w2) : '0;
        mask2 = expV2 ? modelMask(w2) : '1;
        if (ls) begin
            mIdx = 0;
        end else if (wr) begin
            mMem[(mIdx / L) % WU][mIdx % L]   = wd;
            mKnown[(mIdx / L) % WU][mIdx % L] = 1'b1;
            mIdx++;
        end
        @(posedge clk); #1;
        checkOutput("valid1", 128'(rdValid1), 128'(expV1));
        checkOutput("valid2", 128'(rdValid2), 128'(expV2));
        checkOutput("data1", 128'(rdData1 & mask1), 128'(expD1 & mask1));
        checkOutput("data2", 128'(rdData2 & mask2), 128'(expD2 & mask2));
        checkOutput("store_done", 128'(storeDone), 128'(mIdx >= L * WU));
        loadStart = 1'b0; wrSig = 1'b0; rdSig = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < D; a++)
            for (int l = 0; l < L; l++) begin
                mMem[a][l] = '0;
                mKnown[a][l] = 1'b0;
            end

        #2;
        checkOutput("reset valid1", 128'(rdValid1), 128'd0);
        checkOutput("reset valid2", 128'(rdValid2), 128'd0);
        checkOutput("reset data1", 128'(rdData1), 128'd0);
        checkOutput("reset store_done", 128'(storeDone), 128'd0);
        #10 rst = 1'b0;

        // Fill all 50 words with an incrementing ramp.
        for (int i = 1; i <= L * WU; i++) begin
            applyStimulus(1'b0, 1'b1, DW'(i), 1'b0, 16'd0, 16'd0);
            if (i == L * WU - 1) checkOutput("done before last", 128'(storeDone), 128'd0);
        end
        checkOutput("done after 400", 128'(storeDone), 128'd1);

        applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'd0, 16'd24);
        checkOutput("word0 ramp", 128'(rdData1), 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        checkOutput("word49 lane7", 128'(rdData2[127:112]), 128'h0190);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'd3, 16'd0);
        checkOutput("word3 ramp", 128'(rdData1), 128'h0020_001f_001e_001d_001c_001b_001a_0019);
        checkOutput("word25 lane0", 128'(rdData2[15:0]), 128'h00c9);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 16'd3, 16'd0);
        checkOutput("idle data1", 128'(rdData1), 128'd0);

        // Restart mid-word: the weight written alongside load_start must vanish.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b0, 1'b1, 16'h1001, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b0, 1'b1, 16'h1002, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b0, 1'b1, 16'h1003, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b1, 1'b1, 16'h1004, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b0, 1'b1, 16'hAAAA, 1'b0, 16'd0, 16'd0);
        checkOutput("restart store_done", 128'(storeDone), 128'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'd0, 16'd0);
        checkOutput("restart word0", 128'(rdData1[63:0]), 128'h0004_1003_1002_AAAA);

        // Write and read together: port 2 dropped, port 1 sees the old word.
        applyStimulus(1'b0, 1'b1, 16'h5555, 1'b1, 16'd0, 16'd0);
        checkOutput("collide valid2", 128'(rdValid2), 128'd0);
        checkOutput("collide data1", 128'(rdData1[31:0]), 128'h1002_AAAA);

        // Reset in the middle of a word.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, DW'(16'h0300 + i), 1'b0, 16'd0, 16'd0);
        #3 rst = 1'b1; rdSig = 1'b1;
        #1;
        checkOutput("rst store_done", 128'(storeDone), 128'd0);
        mIdx = 0;
        @(posedge clk); #1;
        checkOutput("rst valid1", 128'(rdValid1), 128'd0);
        checkOutput("rst valid2", 128'(rdValid2), 128'd0);
        checkOutput("rst data1", 128'(rdData1), 128'd0);
        #2 rst = 1'b0; rdSig = 1'b0;
        for (int i = 0; i < L; i++) applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b0, 1'b1, 16'h2222, 1'b0, 16'd0, 16'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'd0, 16'd0);
        checkOutput("post-rst word0", 128'(rdData1), {8{16'h1111}});
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 16'd1, 16'd0);
        checkOutput("post-rst word1 lane0", 128'(rdData1[15:0]), 128'h2222);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom % 25) == 0, $urandom % 2, DW'($urandom),
                          $urandom % 2, 16'($urandom), 16'($urandom));
        end

        // Smaller configuration: 4 lanes, 32 words, 10 used.
        for (int i = 1; i <= SL * SWU; i++) begin
            sWrSig = 1'b1; sWrData = DW'(i);
            @(posedge clk); #1;
            if (i == SL * SWU - 1) checkOutput("sweep done early", 128'(sStoreDone), 128'd0);
        end
        sWrSig = 1'b0;
        checkOutput("sweep done", 128'(sStoreDone), 128'd1);
        sRdSig = 1'b1; sRdAddr1 = 16'd33; sRdAddr2 = 16'd10;
        @(posedge clk); #1;
        sRdSig = 1'b0;
        checkOutput("sweep data1", 128'(sRdData1), 128'h0008_0007_0006_0005);
        checkOutput("sweep data2 wrap", 128'(sRdData2), 128'h0010_000f_000e_000d);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/cnn_local_mem_weight_param.md
CNN_LOCAL_MEM_WEIGHT_PARAM -- requirements
Module: cnn_local_mem_weight_param

Interface
REQ-001 SHALL have parameter DATA_W, 16, width of one weight.
REQ-002 SHALL have parameter LANES, 8, weights packed per SRAM word.
REQ-003 SHALL have parameter DEPTH, 64, SRAM words.
REQ-004 SHALL have parameter WORDS_USED, 50, words filled before the write pointer wraps (1..DEPTH).
REQ-005 SHALL have parameter RD2_OFFSET, 25, word offset added to the port-2 read address.
REQ-006 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port load_start, input, 1, pulse that restarts packing at word 0, lane 0 and clears store_done.
REQ-009 SHALL have port write_weight_signal, input, 1, write_weight_data is valid this cycle.
REQ-010 SHALL have port write_weight_data, input, DATA_W, one weight.
REQ-011 SHALL have port read_weight_signal, input, 1, read request on both ports.
REQ-012 SHALL have port read_weight_addr1, input, 16, port-1 word address (low log2(DEPTH) bits used).
REQ-013 SHALL have port read_weight_addr2, input, 16, port-2 word address before offset.
REQ-014 SHALL have port read_weight_data1, output, LANES*DATA_W, port-1 word.
REQ-015 SHALL have port read_weight_data2, output, LANES*DATA_W, port-2 word.
REQ-016 SHALL have port read_valid1, output, 1, read_weight_data1 is valid.
REQ-017 SHALL have port read_valid2, output, 1, read_weight_data2 is valid.
REQ-018 SHALL have port store_done, output, 1, sticky flag: WORDS_USED words completely written.

Function
REQ-019 Packing SHALL use a lane counter (0..LANES-1) and a word counter (0..WORDS_USED-1); each accepted write stores the weight in lane = lane counter of word = word counter, lane 0 at bits [DATA_W-1:0].
REQ-020 Only the addressed lane SHALL be written; per-lane write enables leave the other lanes unchanged.
REQ-021 The lane counter SHALL increment on each write; at LANES-1 it SHALL wrap to 0 and the word counter SHALL increment.
REQ-022 When the word counter is WORDS_USED-1 and the lane wraps, the word counter SHALL return to 0 and store_done SHALL set the next cycle.
REQ-023 store_done SHALL remain set through later writes until load_start or rst.
REQ-024 load_start SHALL take priority over a same-cycle write: counters go to 0, the write is discarded, store_done clears.
REQ-025 Without write_weight_signal, counters and SRAM contents SHALL hold.
REQ-026 Port 1 (SRAM port B) SHALL read word addr1 mod DEPTH; port 2 (SRAM port A) SHALL read (addr2 + RD2_OFFSET) mod DEPTH.
REQ-027 Read latency SHALL be one cycle: read_validN is asserted the cycle after the accepted request and read_weight_dataN carries that word.
REQ-028 read_weight_dataN SHALL be all-zero whenever read_validN is low.
REQ-029 Write and read in the same cycle: the write SHALL own port A, so the port-2 read is dropped (read_valid2 low next cycle); the port-1 read SHALL proceed.
REQ-030 A port-1 read of the word being written that cycle SHALL return the pre-write contents.

Reset
REQ-031 rst SHALL clear the lane counter, word counter, store_done, read_valid1 and read_valid2 asynchronously; data outputs read zero.
REQ-032 SRAM contents SHALL NOT be cleared by rst.
REQ-033 rst during a partial word SHALL abandon it; already-written lanes keep their values.

Structure
REQ-034 Package cnn_pkg SHALL hold the DATA_W default, the lane and word counter widths (derived with $clog2) and the read-port enumeration.
REQ-035 A single sub-module cnn_weight_sram SHALL model a parametrised 2-port SRAM: DEPTH x LANES*DATA_W, per-lane active-low write enable on port A, port B read-only, one-cycle registered read.
REQ-036 The top SHALL contain only the counters, the flag, the address and enable muxing, and the output gating.

Verification (default parameters)
REQ-037 Write 400 weights 0x0001..0x0190 -> word 0 = {0x0008..0x0001}, word 49 lane 7 = 0x0190; store_done rises the cycle after the 400th write.
REQ-038 Read addr1=3, addr2=0 -> next cycle data1 = word 3, data2 = word 25, both valids high; with read_weight_signal low -> both data outputs 0.
REQ-039 Write 3 weights, pulse load_start with a 4th write, write 0xAAAA -> word 0 lane 0 = 0xAAAA, lanes 1-2 keep the old values, the 4th weight is absent, store_done low.
REQ-040 Write and read asserted together with addr1=addr2=0 -> read_valid2 low and data2 = 0; read_valid1 high with the old word 0.
REQ-041 Assert rst after 5 writes, then 8 writes of 0x1111 -> word 0 = all 0x1111, word counter = 1, read_valid flags low during reset.
REQ-042 Parameter sweep LANES=4, DEPTH=32, WORDS_USED=10 -> store_done after 40 writes; port-2 address wraps mod 32.
